// File: rtl/core_pkg.sv
// Shared RV32 front-end types: instruction word, queue entry and imem request/response payloads.
package core_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned ILEN         = 32;

    typedef logic [ILEN-1:0]         instr_t;
    typedef logic [XLEN_DEFAULT-1:0] addr_t;

    localparam instr_t NOP = 32'h0000_0013;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fq_entry_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } imem_req_t;

    typedef struct packed {
        logic   valid;
        instr_t data;
    } imem_resp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, flush and occupancy count; head is valid while count != 0.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: pipelined imem requests, per-request PC tracking,
// buffered {pc, instr} queue toward decode, and redirect with flush of buffered and in-flight fetches.
module fetch_queue
    import core_pkg::*;
#(
    parameter int unsigned     XLEN            = XLEN_DEFAULT,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       set_PC,
    input  logic [XLEN-1:0]            new_PC,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_resp_valid,
    input  instr_t                     imem_resp_data,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output instr_t                     instr,
    output logic [XLEN-1:0]            PC_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);
    localparam int unsigned EW = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   tracker_count;
    logic [XLEN-1:0] tracked_pc;
    logic [EW-1:0]   queue_head;
    logic            may_issue;
    logic            req_fire;
    logic            resp_live;
    logic            queue_pop;

    // The tracker holds exactly the live (non-dropped) in-flight requests,
    // so count + tracker_count is the reserved queue space.
    assign may_issue = (outstanding < OW'(MAX_OUTSTANDING))
                    && ((SW'(count) + SW'(tracker_count)) < SW'(DEPTH));

    assign imem_req_valid = may_issue && !set_PC && !reset;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_live      = imem_resp_valid && (drop_cnt == '0) && !set_PC;
    assign queue_pop      = instr_valid && instr_ready && !set_PC;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + OW'(req_fire) - OW'(imem_resp_valid);
            if (set_PC) begin
                fetch_pc <= {new_PC[XLEN-1:2], 2'b00};
                drop_cnt <= outstanding - OW'(imem_resp_valid);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
            end
        end
    end

    sync_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_pc_tracker (
        .clock     (clock),
        .reset     (reset),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (resp_live),
        .flush     (set_PC),
        .count     (tracker_count),
        .head      (tracked_pc)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (resp_live),
        .push_data ({tracked_pc, imem_resp_data}),
        .pop       (queue_pop),
        .flush     (set_PC),
        .count     (count),
        .head      (queue_head)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? queue_head[ILEN-1:0] : NOP;
    assign PC_out      = queue_head[EW-1:ILEN];

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: in-order variable-latency memory model plus a transaction-level
// scoreboard of expected request addresses and decoded {pc, instr} pairs.
module tb_fetch_queue;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          MAXO   = 2;
    localparam int          DEP    = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        set_PC;
    logic [31:0] new_PC;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] PC_out;
    logic [2:0]  count;

    fetch_queue #(.XLEN(32), .DEPTH(DEP), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)) dut (
        .clock           (clock),
        .reset           (reset),
        .set_PC          (set_PC),
        .new_PC          (new_PC),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .PC_out          (PC_out),
        .count           (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] mdl[$];
    logic [31:0] exp_req;
    int          epoch, cyc, last_due, pops;
    int          checks, errors;
    int          k_lat_min, k_lat_max, k_rdy, k_mem, k_redir, k_rst;
    logic        f_set, f_reset;
    logic [31:0] f_newpc;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic        post_redir, pop_armed;
    logic [31:0] redir_addr, first_pop_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic pct(input int p);
        return int'($urandom % 100) < p;
    endfunction

    function automatic logic [31:0] rand_pc();
        case ($urandom % 3)
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 | ($urandom % 16);
            default: return $urandom % 64;
        endcase
    endfunction

    // One clock cycle: drive at negedge, then check and advance the model for the coming edge.
    task automatic tick();
        pend_t p;
        int    d;
        @(negedge clock);
        reset          = f_reset || pct(k_rst);
        set_PC         = !reset && (f_set || pct(k_redir));
        new_PC         = f_set ? f_newpc : rand_pc();
        instr_ready    = pct(k_rdy);
        imem_req_ready = pct(k_mem);
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_of(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        f_set   = 1'b0;
        f_reset = 1'b0;
        #1;
        chk("count", 64'(count), 64'(mdl.size()));
        chk("instr_valid", 64'(instr_valid), 64'(mdl.size() != 0));
        if (reset || set_PC) chk("req_off", 64'(imem_req_valid), 64'd0);
        if (prev_stall && !reset && !set_PC) begin
            chk("hold_valid", 64'(imem_req_valid), 64'd1);
            chk("hold_addr", 64'(imem_req_addr), 64'(prev_addr));
        end
        if (post_redir) begin
            redir_addr = imem_req_addr;
            post_redir = 1'b0;
        end
        if (instr_valid && instr_ready && !set_PC && !reset && mdl.size() > 0) begin
            chk("pc_out", 64'(PC_out), 64'(mdl[0]));
            chk("instr", 64'(instr), 64'(word_of(mdl[0])));
            if (pop_armed) begin
                first_pop_pc = PC_out;
                pop_armed    = 1'b0;
            end
            void'(mdl.pop_front());
            pops++;
        end
        if (imem_req_valid && imem_req_ready && !reset) begin
            chk("req_addr", 64'(imem_req_addr), 64'(exp_req));
            d = cyc + int'($urandom_range(k_lat_max, k_lat_min));
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            pend.push_back('{addr: imem_req_addr, epoch: epoch, due: d});
            exp_req = exp_req + 32'd4;
        end
        if (imem_resp_valid) begin
            p = pend.pop_front();
            if (p.epoch == epoch && !set_PC) mdl.push_back(p.addr);
        end
        chk("outstanding_le_max", 64'(pend.size() <= MAXO), 64'd1);
        if (set_PC) begin
            mdl.delete();
            epoch++;
            exp_req    = new_PC & 32'hFFFF_FFFC;
            post_redir = 1'b1;
            pop_armed  = 1'b1;
        end
        if (reset) begin
            mdl.delete();
            pend.delete();
            epoch++;
            exp_req  = RST_PC;
            last_due = 0;
        end
        prev_stall = imem_req_valid && !imem_req_ready && !reset && !set_PC;
        prev_addr  = imem_req_addr;
        cyc++;
    endtask

    task automatic knobs(input int lmin, input int lmax, input int rdy, input int mem,
                         input int redir, input int rst);
        k_lat_min = lmin; k_lat_max = lmax; k_rdy = rdy; k_mem = mem; k_redir = redir; k_rst = rst;
    endtask

    initial begin
        logic [31:0] a0;
        int          n;
        checks = 0; errors = 0; cyc = 1; epoch = 0; last_due = 0; pops = 0;
        f_set = 0; f_reset = 0; f_newpc = '0; prev_stall = 0; prev_addr = '0;
        post_redir = 0; pop_armed = 0; redir_addr = '0; first_pop_pc = '0;
        exp_req = RST_PC;
        reset = 1; set_PC = 0; new_PC = '0; imem_req_ready = 0;
        imem_resp_valid = 0; imem_resp_data = '0; instr_ready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        #1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_valid", 64'(instr_valid), 64'd0);
        chk("reset_req", 64'(imem_req_valid), 64'd1);
        chk("reset_addr", 64'(imem_req_addr), 64'(RST_PC));

        // Streaming with 1-cycle memory across the address wrap; one instruction per cycle.
        knobs(1, 1, 100, 100, 0, 0);
        repeat (10) tick();
        pops = 0;
        repeat (30) tick();
        chk("throughput", 64'(pops), 64'd30);

        // Decode stalled: queue fills to DEPTH and requests stop.
        knobs(1, 1, 0, 100, 0, 0);
        repeat (12) tick();
        chk("full_count", 64'(count), 64'(DEP));
        chk("full_noreq", 64'(imem_req_valid), 64'd0);
        knobs(1, 1, 100, 100, 0, 0);
        repeat (10) tick();

        // Latency 3 with two in flight, then redirect to an unaligned target.
        knobs(3, 3, 100, 100, 0, 0);
        n = 0;
        while (pend.size() != MAXO && n < 20) begin
            tick();
            n++;
        end
        chk("two_in_flight", 64'(pend.size()), 64'(MAXO));
        f_set = 1; f_newpc = 32'h0000_0103;
        tick();
        tick();
        chk("redir_addr", 64'(redir_addr), 64'h100);
        repeat (15) tick();
        chk("redir_head", 64'(first_pop_pc), 64'h100);

        // Memory not ready: request held stable.
        knobs(1, 1, 100, 0, 0, 0);
        repeat (4) tick();
        a0 = imem_req_addr;
        chk("stall_valid", 64'(imem_req_valid), 64'd1);
        repeat (5) tick();
        chk("stall_addr", 64'(imem_req_addr), 64'(a0));
        chk("stall_valid_end", 64'(imem_req_valid), 64'd1);

        // Mid-stream reset returns to RESET_PC with an empty queue.
        knobs(1, 2, 50, 100, 0, 0);
        repeat (10) tick();
        f_reset = 1;
        tick();
        tick();
        chk("mid_reset_count", 64'(count), 64'd0);
        repeat (12) tick();

        // Fully randomized traffic with redirects and occasional resets.
        knobs(1, 4, 70, 70, 8, 1);
        repeat (3000) tick();
        knobs(1, 3, 90, 90, 25, 0);
        repeat (1000) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupled instruction-fetch front end for the pipelined RV32 core; it replaces the single-register fetch stage.
- Issues in-order, pipelined requests to a variable-latency instruction memory and buffers returned words with their PCs in a parametrised FIFO.
- Presents one instruction per cycle to decode through a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.

Parameters:
XLEN, 32, width of PC and address (32 or 64)
DEPTH, 4, queue entries; power of two, >= 2
MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests; 1..DEPTH
RESET_PC, 0, fetch address after reset; must be word aligned

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
set_PC  in  1  redirect request from execute
new_PC  in  XLEN  redirect target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word address of request
imem_resp_valid  in  1  response valid; in request order; no backpressure
imem_resp_data  in  32  instruction word
instr_valid  out  1  queue head valid
instr_ready  in  1  decode consumes head
instr  out  32  head instruction
PC_out  out  XLEN  PC of head instruction
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset values: instr_valid=0, imem_req_valid=0, count=0, fetch_pc=RESET_PC, outstanding=0, drop_cnt=0. instr and PC_out are don't-care while instr_valid=0. Reset overrides every other input in that cycle. imem shares the reset, so no stale responses arrive after reset.
- Credit: may_issue = (outstanding < MAX_OUTSTANDING) && (count + outstanding - drop_cnt < DEPTH). Space for every live response is reserved at issue, so a response never meets a full queue.
- imem_req_valid = may_issue && !set_PC && !reset (combinational). imem_req_addr = fetch_pc.
- Request fire (valid && ready): fetch_pc += 4 (modulo 2^XLEN, wraps silently) and outstanding increments.
- Response: outstanding decrements.
  - If drop_cnt > 0: the word is discarded and drop_cnt decrements.
  - Otherwise {fetch PC, word} is pushed at the tail. The PC comes from a per-request PC tracker, a small FIFO of MAX_OUTSTANDING entries.
- Zero-latency hold: a pushed entry is visible at the head no earlier than the next cycle (registered queue).
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect (set_PC=1, highest priority after reset):
  - Queue emptied (count=0, instr_valid=0 next cycle).
  - fetch_pc <= {new_PC[XLEN-1:2], 2'b00}; the low bits are forced to zero.
  - drop_cnt <= outstanding - imem_resp_valid. Any response arriving in the redirect cycle is discarded; the PC tracker is flushed.
  - No request issues in the redirect cycle. The first request to new_PC is offered in the next cycle.
  - A pop in the redirect cycle is ignored (decode is flushed by the same event).
  - Back-to-back redirects: the latest target wins; drop_cnt is recomputed each time.
- imem_req_valid may drop without handshake only on set_PC or a credit change caused by redirect. Otherwise, once asserted, valid and addr are held until ready.
- Throughput: with 1-cycle memory, instr_ready=1 and MAX_OUTSTANDING>=2, a steady state of one instruction per cycle is required.

Decomposition:
- Shared package core_pkg: XLEN default, NOP encoding 32'h00000013, queue entry struct {pc, instr}, imem request/response typedefs.
- One sub-module, sync_fifo (WIDTH, DEPTH; push, pop, flush, count, head). It is instantiated twice: once for the instruction queue (WIDTH=XLEN+32) and once for the PC tracker.

Test Plan:
1. Reset then release, 1-cycle memory returning word=addr, instr_ready=1 → requests at 0x0, 0x4, 0x8…; decode sees PC_out/instr 0x0, 0x4, … on consecutive cycles after the initial latency.
2. instr_ready=0, DEPTH=4 → exactly 4 entries buffered, count=4, imem_req_valid=0 with no further requests; release ready → 4 pops in order, fetch resumes at 0x10.
3. Memory latency 3 with 2 outstanding (0x8, 0xC), set_PC with new_PC=0x103 → both late responses discarded, next request address 0x100, next head PC_out=0x100.
4. set_PC asserted in the same cycle as a response and a pop → response dropped, queue empty next cycle, drop_cnt = outstanding-1.
5. imem_req_ready held low 5 cycles → imem_req_valid and imem_req_addr stable throughout, no PC advance.
6. RESET_PC=0xFFFFFFF8, XLEN=32 → requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0; reset asserted mid-stream → count=0, instr_valid=0, next request at RESET_PC.
